// File: rtl/gt_uint8_arbiter.sv
// gt_uint8_arbiter: round-robin arbiter sharing one unsigned greater-than comparator
// across NUM_REQ requesters, with a single registered result slot.
module gt_uint_nbit #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_y
);
  generate
    if (IMPL_TYPE == 0) begin : g_cmp
      assign o_y = i_a > i_b;
    end else begin : g_sub
      // b - a borrows exactly when a > b
      logic [WIDTH:0] w_diff;
      assign w_diff = {1'b0, i_b} - {1'b0, i_a};
      assign o_y    = w_diff[WIDTH];
    end
  endgenerate
endmodule

module gt_uint8_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_y,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          r_state, w_next;
  logic [ID_W-1:0] r_last, r_id, w_gnt;
  logic            r_y, w_y, w_free, w_accept;
  logic [NUM_REQ-1:0] w_rot;
  logic [WIDTH-1:0] w_a_arr [NUM_REQ];
  logic [WIDTH-1:0] w_b_arr [NUM_REQ];
  int              w_off, w_sum;
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_op
      assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end
  endgenerate
  assign w_free = (r_state == EMPTY) | rsp_ready;
  // rotate so bit 0 is the requester just after the last grant
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> (int'(r_last) + 1));
  always_comb begin
    w_off = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) w_off = w_rot[j] ? j : w_off;
    w_sum = int'(r_last) + 1 + w_off;
    w_gnt = ID_W'(w_sum >= NUM_REQ ? w_sum - NUM_REQ : w_sum);
  end
  assign req_ready = (rst_n & w_free & (|req_valid)) ? NUM_REQ'(1) << w_gnt : '0;
  assign w_accept  = |req_ready;
  gt_uint_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_gt (
    .i_a(w_a_arr[w_gnt]),
    .i_b(w_b_arr[w_gnt]),
    .o_y(w_y)
  );
  always_comb w_next = w_accept ? FULL : (rsp_ready ? EMPTY : r_state);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_y     <= 1'b0;
      r_id    <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_y    <= w_y;
        r_id   <= w_gnt;
        r_last <= w_gnt;
      end
    end
  end
  assign rsp_valid = r_state == FULL;
  assign rsp_y     = r_y;
  assign rsp_id    = r_id;
endmodule

// File: tb/tb_gt_uint8_arbiter.sv
// tb_gt_uint8_arbiter: directed scenarios plus randomized traffic against a
// behavioural round-robin/compare model, checked every cycle on the falling edge.
module tb_gt_uint8_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_y;
  logic [1:0]     rsp_id;
  int total = 0;
  int bad = 0;
  bit m_full, m_y;
  int m_id, m_last;

  gt_uint8_arbiter #(.WIDTH(W), .NUM_REQ(N), .IMPL_TYPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  function automatic int opa(int i);
    return int'(req_a[i*W +: W]);
  endfunction
  function automatic int opb(int i);
    return int'(req_b[i*W +: W]);
  endfunction
  function automatic int exp_gnt();
    if (m_full && !rsp_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_y    <= 1'b0;
      m_id   <= 0;
      m_last <= N - 1;
    end else if (exp_gnt() >= 0) begin
      m_full <= 1'b1;
      m_id   <= exp_gnt();
      m_last <= exp_gnt();
      m_y    <= opa(exp_gnt()) > opb(exp_gnt());
    end else if (rsp_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_valid", int'(rsp_valid), 0);
    end else begin
      chk("model_ready", int'(req_ready), exp_gnt() >= 0 ? (1 << exp_gnt()) : 0);
      chk("model_valid", int'(rsp_valid), int'(m_full));
      if (m_full) begin
        chk("model_y", int'(rsp_y), int'(m_y));
        chk("model_id", int'(rsp_id), m_id);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int ba [4] = '{37, 255, 0, 128};
    int bb [4] = '{37, 0, 255, 127};
    int by [4] = '{0, 1, 0, 1};
    logic [N-1:0] acc;
    repeat (3) step();
    chk("reset_valid", int'(rsp_valid), 0);
    chk("reset_y", int'(rsp_y), 0);
    chk("reset_id", int'(rsp_id), 0);
    rst_n = 1'b1;
    // single request
    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'd200;
    req_b[2*W +: W] = 8'd100;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", int'(req_ready), 4);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", int'(rsp_valid), 1);
    chk("single_y", int'(rsp_y), 1);
    chk("single_id", int'(rsp_id), 2);
    step();
    // all requesters after reset
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_order", int'(req_ready), 1 << (k % 4));
      step();
    end
    req_valid = '0;
    step();
    // boundary operands
    for (int c = 0; c < 4; c++) begin
      req_a[0 +: W] = W'(ba[c]);
      req_b[0 +: W] = W'(bb[c]);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("bound_ready", int'(req_ready), 1);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("bound_y", int'(rsp_y), by[c]);
      step();
    end
    // backpressure
    req_a[1*W +: W] = 8'd10;
    req_b[1*W +: W] = 8'd20;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_fill", int'(req_ready), 2);
    step();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    req_a[2*W +: W] = 8'd9;
    req_b[2*W +: W] = 8'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", int'(req_ready), 0);
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_id", int'(rsp_id), 1);
      chk("bp_y", int'(rsp_y), 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", int'(req_ready), 4);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_id", int'(rsp_id), 2);
    chk("bp_next_y", int'(rsp_y), 1);
    step();
    // withdrawal while blocked
    req_valid = 4'b0100;
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("wd_blocked", int'(req_ready), 0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("wd_dropped", int'(req_ready), 0);
    step();
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("wd_after", int'(req_ready), 1);
    step();
    req_valid = '0;
    step();
    // reset mid-operation
    req_valid = 4'b0010;
    step();
    rsp_ready = 1'b0;
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    req_valid = 4'hF;
    #1;
    chk("mid_rst_ready", int'(req_ready), 0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", int'(rsp_valid), 0);
    step();
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", int'(req_ready), 8);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_id", int'(rsp_id), 3);
    chk("post_rst_rv", int'(rsp_valid), 1);
    step();
    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      rsp_ready = $urandom_range(0, 9) < 7;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
          req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? req_a[i*W +: W] : W'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
